// File: rtl/rs232_pkg.sv
// Shared RS-232 definitions: baud selection, divisor table, receiver FSM states and 8N1 frame constants.
package rs232_pkg;

  typedef enum logic [1:0] {
    BAUD_9600   = 2'b00,
    BAUD_19200  = 2'b01,
    BAUD_57600  = 2'b10,
    BAUD_115200 = 2'b11
  } baud_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int BIT_IDX_W = $clog2(DATA_BITS);
  localparam int CNT_W     = 13;

  // Elaboration-time only: callers fold the result into constants.
  function automatic int baud_div(input int clk_hz, input baud_e b);
    int rate;
    case (b)
      BAUD_9600:   rate = 9600;
      BAUD_19200:  rate = 19200;
      BAUD_57600:  rate = 57600;
      default:     rate = 115200;
    endcase
    return clk_hz / rate;
  endfunction

endpackage

// File: rtl/rs232_rx_frame_if.sv
// Link between a UART bit-timing FSM and its baud counter: divisor load/restart and tick returns.
interface rs232_rx_frame_if;
  import rs232_pkg::*;

  logic  load;
  logic  clr;
  baud_e setting;
  logic  half_tick;
  logic  full_tick;

  modport master (
    output load,
    output clr,
    output setting,
    input  half_tick,
    input  full_tick
  );

  modport slave (
    input  load,
    input  clr,
    input  setting,
    output half_tick,
    output full_tick
  );

endinterface

// File: rtl/rs232_baud_cnt.sv
// Bit-period counter with a divisor latched on load; reports half-bit and full-bit positions.
module rs232_baud_cnt
  import rs232_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input logic             clk,
  input logic             rst,
  rs232_rx_frame_if.slave bif
);

  localparam logic [CNT_W-1:0] DIV_9600   = CNT_W'(baud_div(CLK_HZ, BAUD_9600));
  localparam logic [CNT_W-1:0] DIV_19200  = CNT_W'(baud_div(CLK_HZ, BAUD_19200));
  localparam logic [CNT_W-1:0] DIV_57600  = CNT_W'(baud_div(CLK_HZ, BAUD_57600));
  localparam logic [CNT_W-1:0] DIV_115200 = CNT_W'(baud_div(CLK_HZ, BAUD_115200));

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sel_div;
  logic             half_hit;
  logic             full_hit;

  always_comb begin
    sel_div = DIV_9600;
    case (bif.setting)
      BAUD_9600:   sel_div = DIV_9600;
      BAUD_19200:  sel_div = DIV_19200;
      BAUD_57600:  sel_div = DIV_57600;
      BAUD_115200: sel_div = DIV_115200;
      default:     sel_div = DIV_9600;
    endcase
  end

  // Ticks look at the latched divisor so a setting change only matters at the next load.
  assign half_hit = (cnt_q == ((div_q >> 1) - CNT_W'(1)));
  assign full_hit = (cnt_q == (div_q - CNT_W'(1)));

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q + CNT_W'(1);
    if (bif.load) begin
      div_d = sel_div;
      cnt_d = '0;
    end else if (bif.clr || full_hit) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= DIV_9600;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign bif.half_tick = half_hit;
  assign bif.full_tick = full_hit;

endmodule

// File: rtl/rs232_rx_frame.sv
// 8N1 serial receiver: synchronizes rx, frames start/data/stop, and hands bytes out with a valid/ack pair.
module rs232_rx_frame
  import rs232_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] buad_setting,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);

  rs232_rx_frame_if bif ();

  rs232_baud_cnt #(
    .CLK_HZ (CLK_HZ)
  ) u_baud_cnt (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  rx_state_e              state_q, state_d;
  logic                   rx_s1_q, rx_s1_d;
  logic                   rx_s_q, rx_s_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [1:0]             fill_q, fill_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   fall;
  logic                   load;
  logic                   clr;

  // Reset seeds the synchronizer high; fill_q keeps that artificial high out of
  // rx_prev so a line held low through reset is not mistaken for a start edge.
  assign fall = rx_prev_q & ~rx_s_q;

  always_comb begin
    rx_s1_d     = rx;
    rx_s_d      = rx_s1_q;
    fill_d      = {fill_q[0], 1'b1};
    rx_prev_d   = fill_q[1] ? rx_s_q : 1'b0;
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    load        = 1'b0;
    clr         = 1'b0;

    if (rx_valid_q && rx_ack) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          load    = 1'b1;
        end
      end
      ST_START: begin
        if (bif.half_tick) begin
          if (!rx_s_q) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
            clr       = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (bif.full_tick) begin
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
          if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (bif.full_tick) begin
          state_d = ST_IDLE;
          if (rx_s_q) begin
            // A byte landing together with an ack replaces the old one cleanly.
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q & ~rx_ack;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bif.load    = load;
  assign bif.clr     = clr;
  assign bif.setting = baud_e'(buad_setting);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rx_s1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b0;
      fill_q      <= 2'b00;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_s1_q     <= rx_s1_d;
      rx_s_q      <= rx_s_d;
      rx_prev_q   <= rx_prev_d;
      fill_q      <= fill_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_rs232_rx_frame.sv
// Bench for rs232_rx_frame: directed scenarios plus random frames against a frame-level timing model.
module tb_rs232_rx_frame;

  // Scaled clock keeps 9600-baud frames short; divisors are 520/260/86/43.
  localparam int CLK_HZ = 5_000_000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] buad_setting = 2'b11;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  rs232_rx_frame #(
    .CLK_HZ (CLK_HZ)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .buad_setting (buad_setting),
    .rx           (rx),
    .rx_ack       (rx_ack),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  int div_tab [4] = '{520, 260, 86, 43};

  typedef struct {
    longint     due;
    logic [7:0] data;
    bit         good;
  } evt_t;

  evt_t       evq[$];
  longint     cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_err;
  logic       m_ovr;
  bit         ack_rand = 0;
  bit         ack_on_due = 0;
  longint     ack_at = -1;
  longint     rise_cyc = -1;
  int         err_cnt = 0;
  int         ovr_cnt = 0;
  logic       prev_v = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a frame started at cycle n0 resolves at n0 + 3 + DIV/2 + 9*DIV.
  evt_t ev;
  always @(posedge clk) begin
    cyc   = cyc + 1;
    m_err = 1'b0;
    m_ovr = 1'b0;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      evq.delete();
    end else begin
      if (evq.size() > 0 && evq[0].due == cyc) begin
        ev = evq.pop_front();
        if (ev.good) begin
          m_ovr   = m_valid && !rx_ack;
          m_valid = 1'b1;
          m_data  = ev.data;
        end else begin
          m_err = 1'b1;
          if (m_valid && rx_ack) m_valid = 1'b0;
        end
      end else if (m_valid && rx_ack) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("rx_valid", 32'(rx_valid), 32'(m_valid));
    check("rx_data", 32'(rx_data), 32'(m_data));
    check("frame_err", 32'(frame_err), 32'(m_err));
    check("overrun", 32'(overrun), 32'(m_ovr));
    if (rx_valid && !prev_v) rise_cyc = cyc;
    if (frame_err) err_cnt++;
    if (overrun) ovr_cnt++;
    prev_v = rx_valid;
  end

  always @(posedge clk) begin
    #1;
    if (ack_rand)        rx_ack = ($urandom_range(0, 3) == 0);
    else if (ack_on_due) rx_ack = (evq.size() > 0 && evq[0].due == cyc + 1);
    else                 rx_ack = (ack_at == cyc + 1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input int set,
                            input int mid_set, output longint n0);
    int div;
    buad_setting = 2'(set);
    tick(1);
    div = div_tab[set];
    n0  = cyc;
    evq.push_back(evt_t'{due: n0 + 3 + div / 2 + 9 * div, data: d, good: stop});
    for (int k = 0; k < 10; k++) begin
      rx = (k == 0) ? 1'b0 : (k == 9) ? stop : d[k-1];
      tick(div);
      if (k == 1 && mid_set >= 0) buad_setting = 2'(mid_set);
    end
    rx = 1'b1;
    if (!stop) tick(div);
  endtask

  task automatic false_start(input int set, input int low_len);
    buad_setting = 2'(set);
    rx = 1'b0;
    tick(low_len);
    rx = 1'b1;
    tick(div_tab[set] + 5);
  endtask

  initial begin
    longint n0;
    int     e0;
    int     o0;
    logic [7:0] rd;

    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset rx_valid", 32'(rx_valid), 32'h0);
    check("reset rx_data", 32'(rx_data), 32'h00);
    check("reset frame_err", 32'(frame_err), 32'h0);
    check("reset overrun", 32'(overrun), 32'h0);
    tick(5);

    // 0xA5 at the fastest setting, then acknowledge it.
    send_frame(8'hA5, 1'b1, 3, -1, n0);
    check("A5 data", 32'(rx_data), 32'hA5);
    check("A5 latency", 32'(rise_cyc - n0), 32'd411);
    ack_at = cyc + 3;
    repeat (3) @(negedge clk);
    check("A5 valid before ack", 32'(rx_valid), 32'h1);
    @(negedge clk);
    check("A5 valid after ack", 32'(rx_valid), 32'h0);
    tick(20);

    // Short low pulse: false start, nothing reported.
    false_start(3, 10);
    check("false start valid", 32'(rx_valid), 32'h0);

    // Stop bit low.
    e0 = err_cnt;
    send_frame(8'h3C, 1'b0, 3, -1, n0);
    check("3C frame_err pulses", 32'(err_cnt - e0), 32'd1);
    check("3C valid", 32'(rx_valid), 32'h0);
    tick(10);

    // Back-to-back without ack: one overrun, last byte kept.
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 3, -1, n0);
    send_frame(8'h22, 1'b1, 3, -1, n0);
    check("b2b overrun count", 32'(ovr_cnt - o0), 32'd1);
    check("b2b data", 32'(rx_data), 32'h22);
    check("b2b valid", 32'(rx_valid), 32'h1);
    ack_at = cyc + 2;
    tick(5);

    // Same, with ack landing on the second completion cycle.
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 3, -1, n0);
    ack_on_due = 1;
    send_frame(8'h22, 1'b1, 3, -1, n0);
    ack_on_due = 0;
    check("ack-on-done overrun count", 32'(ovr_cnt - o0), 32'd0);
    check("ack-on-done data", 32'(rx_data), 32'h22);
    check("ack-on-done valid", 32'(rx_valid), 32'h1);
    ack_at = cyc + 2;
    tick(5);

    // Reset in the middle of a frame with the line still low afterwards.
    buad_setting = 2'b11;
    rx = 1'b0;
    tick(4 * 43);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(43);
    rx = 1'b1;
    tick(2 * 43);
    check("post-abort valid", 32'(rx_valid), 32'h0);
    send_frame(8'h5A, 1'b1, 3, -1, n0);
    check("5A data", 32'(rx_data), 32'h5A);
    check("5A valid", 32'(rx_valid), 32'h1);
    ack_at = cyc + 2;
    tick(5);

    // Setting change mid-frame applies only to the following frame.
    send_frame(8'h96, 1'b1, 3, 0, n0);
    check("96 data", 32'(rx_data), 32'h96);
    check("96 latency", 32'(rise_cyc - n0), 32'd411);
    ack_at = cyc + 2;
    tick(5);
    send_frame(8'h69, 1'b1, 0, -1, n0);
    check("69 data", 32'(rx_data), 32'h69);
    check("69 latency", 32'(rise_cyc - n0), 32'd4943);
    ack_at = cyc + 2;
    tick(5);

    // Random traffic.
    ack_rand = 1;
    for (int i = 0; i < 24; i++) begin
      int set;
      set = $urandom_range(1, 3);
      if ($urandom_range(0, 5) == 0) false_start(set, $urandom_range(2, div_tab[set] / 2 - 4));
      rd = 8'($urandom);
      send_frame(rd, ($urandom_range(0, 6) != 0), set,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1, n0);
      tick($urandom_range(0, 40));
    end
    ack_rand = 0;
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
